// File: rtl/glb_ld_strm.sv
// GLB load-stream engine: reads consecutive 64-bit bank words and unpacks them into a CGRA word stream.
// Define GLB_LD_STRM_PERF_EN to add the stall_cnt output (cycles with strm_valid && !strm_ready while busy).
module glb_ld_strm #(
    parameter int BANK_DATA_WIDTH = 64,
    parameter int CGRA_DATA_WIDTH = 16,
    parameter int GLB_ADDR_WIDTH  = 22,
    parameter int LEN_WIDTH       = 16,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_start,
    input  logic [GLB_ADDR_WIDTH-1:0]  cfg_start_addr,
    input  logic [LEN_WIDTH-1:0]       cfg_num_words,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_req_valid,
    input  logic                       rd_req_ready,
    output logic [GLB_ADDR_WIDTH-1:0]  rd_req_addr,
    input  logic                       rd_data_valid,
    input  logic [BANK_DATA_WIDTH-1:0] rd_data,
    output logic                       strm_valid,
    input  logic                       strm_ready,
    output logic [CGRA_DATA_WIDTH-1:0] strm_data
`ifdef GLB_LD_STRM_PERF_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);
    localparam int LANES  = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] { IDLE, RUN, DRAIN } state_e;

    state_e                     state_q, state_d;
    logic                       done_q, done_d;
    logic [GLB_ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]       req_left_q;
    logic [LEN_WIDTH-1:0]       words_left_q;
    logic [CNT_W-1:0]           outst_q;
    logic [CNT_W-1:0]           occ_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LANE_W-1:0]          lane_q;
    logic [BANK_DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    logic                       start_acc, req_fire, push, pop, hs, last_word;
    logic [CNT_W:0]             inflight;
    logic [LEN_WIDTH-1:0]       req_total;

    assign start_acc = cfg_start && (state_q == IDLE);
    assign req_total = cfg_num_words / LEN_WIDTH'(LANES)
                     + LEN_WIDTH'((cfg_num_words % LEN_WIDTH'(LANES)) != '0);

    // Credits cover both requests in flight and words already buffered, so the FIFO can never overflow.
    assign inflight     = {1'b0, outst_q} + {1'b0, occ_q};
    assign rd_req_valid = (state_q == RUN) && (req_left_q != '0)
                        && (inflight < (CNT_W+1)'(FIFO_DEPTH));
    assign rd_req_addr  = addr_q;
    assign req_fire     = rd_req_valid && rd_req_ready;

    // Returns arriving with nothing outstanding belong to a stream killed by reset and are dropped.
    assign push      = rd_data_valid && (outst_q != '0);
    assign strm_valid = (occ_q != '0);
    assign hs        = strm_valid && strm_ready;
    assign last_word = (words_left_q == LEN_WIDTH'(1));
    assign pop       = hs && ((lane_q == LANE_W'(LANES - 1)) || last_word);
    assign strm_data = strm_valid ? fifo_q[rd_ptr_q][int'(lane_q) * CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH]
                                  : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // NOTE: every signal driven here gets a default first; a path that skips an assignment infers a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_words == '0) done_d  = 1'b1;
                    else                     state_d = RUN;
                end
            end
            RUN: begin
                if (req_fire && (req_left_q == LEN_WIDTH'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (hs && last_word) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            addr_q       <= '0;
            req_left_q   <= '0;
            words_left_q <= '0;
            outst_q      <= '0;
            occ_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lane_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_acc) begin
                addr_q       <= cfg_start_addr & ~GLB_ADDR_WIDTH'(7);
                req_left_q   <= req_total;
                words_left_q <= cfg_num_words;
            end else begin
                if (req_fire) begin
                    addr_q     <= addr_q + GLB_ADDR_WIDTH'(8);
                    req_left_q <= req_left_q - 1'b1;
                end
                if (hs) words_left_q <= words_left_q - 1'b1;
            end
            case ({req_fire, push})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: ;
            endcase
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: ;
            endcase
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (pop)     lane_q <= '0;
            else if (hs) lane_q <= lane_q + 1'b1;
        end
    end

    // NOTE: the buffer storage has no reset; strm_data is gated by strm_valid so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= rd_data;
    end

`ifdef GLB_LD_STRM_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (busy && strm_valid && !strm_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
